// File: rtl/event_fifo_pkg.sv
// Shared definitions for the trigger event FIFO reader: word tags, word width
// and the framing state encoding.
package event_fifo_pkg;

    localparam int unsigned EVT_WORD_W = 18;

    localparam logic [1:0] TAG_DATA    = 2'b00;
    localparam logic [1:0] TAG_HEADER  = 2'b01;
    localparam logic [1:0] TAG_TRAILER = 2'b10;
    localparam logic [1:0] TAG_RSVD    = 2'b11;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_EVENT = 1'b1
    } evt_state_t;

endpackage

// File: rtl/event_skid_buffer.sv
// Small circular buffer that absorbs FIFO read latency; the head entry is
// visible combinationally so a captured word can be presented next cycle.
module event_skid_buffer
    import event_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = EVT_WORD_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/event_fifo_reader.sv
// Drains the trigger event FIFO, checks header/data/trailer framing and presents
// a valid/ready payload stream with start/end markers, an event count and an error flag.
module event_fifo_reader
    import event_fifo_pkg::*;
#(
    parameter  int unsigned SKID_DEPTH = 4,
    parameter  int unsigned DATA_WIDTH = 16,
    localparam int unsigned WORD_W     = DATA_WIDTH + 2,
    localparam int unsigned CNT_W      = $clog2(SKID_DEPTH) + 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    input  logic [WORD_W-1:0]     i_fifo_q,
    output logic                  o_fifo_re,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_out_start,
    output logic                  o_out_end,
    output logic [15:0]           o_event_count,
    output logic                  o_frame_error,
    input  logic                  i_error_clear,
    output logic                  o_busy
);

    localparam logic [CNT_W:0] DEPTH_LIM = SKID_DEPTH[CNT_W:0];

    evt_state_t        r_state;
    logic              r_inflight;
    logic [15:0]       r_event_count;
    logic              r_frame_error;

    logic [WORD_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_credit_used;
    logic [1:0]        w_tag;
    logic              w_head_valid;
    logic              w_is_hdr;
    logic              w_is_data;
    logic              w_is_trl;
    logic              w_forward;
    logic              w_discard;
    logic              w_accept;
    logic              w_pop;
    logic              w_err_set;

    // Credits cover both stored words and the word still on its way back from the FIFO.
    assign w_credit_used = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign o_fifo_re     = ~i_reset & i_enable & ~i_fifo_empty & (w_credit_used < DEPTH_LIM);

    event_skid_buffer #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (WORD_W)
    ) u_skid (
        .i_clk       (i_clock),
        .i_rst       (i_reset),
        .i_push      (r_inflight),
        .i_push_data (i_fifo_q),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign w_tag        = w_head[WORD_W-1 -: 2];
    assign w_head_valid = (w_count != '0);
    assign w_is_hdr     = (w_tag == TAG_HEADER);
    assign w_is_data    = (w_tag == TAG_DATA);
    assign w_is_trl     = (w_tag == TAG_TRAILER);

    // Anything not forwardable in the current state is dropped in a single cycle.
    assign w_forward = w_head_valid &
                       (w_is_hdr | ((w_is_data | w_is_trl) & (r_state == ST_IN_EVENT)));
    assign w_discard = w_head_valid & ~w_forward;
    assign w_accept  = w_forward & i_out_ready;
    assign w_pop     = w_accept | w_discard;
    assign w_err_set = w_discard | (w_accept & w_is_hdr & (r_state == ST_IN_EVENT));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_inflight    <= 1'b0;
            r_event_count <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_inflight <= o_fifo_re;
            if (w_accept && w_is_hdr) begin
                r_state <= ST_IN_EVENT;
            end else if (w_accept && w_is_trl) begin
                r_state       <= ST_IDLE;
                r_event_count <= r_event_count + 16'd1;
            end
            if (w_err_set) begin
                r_frame_error <= 1'b1;
            end else if (i_error_clear) begin
                r_frame_error <= 1'b0;
            end
        end
    end

    assign o_out_valid   = w_forward;
    assign o_out_data    = w_forward ? w_head[DATA_WIDTH-1:0] : '0;
    assign o_out_start   = w_forward & w_is_hdr;
    assign o_out_end     = w_forward & w_is_trl;
    assign o_event_count = r_event_count;
    assign o_frame_error = r_frame_error;
    assign o_busy        = (r_state == ST_IN_EVENT) | r_inflight | w_head_valid;

endmodule

// File: tb/tb_event_fifo_reader.sv
// Directed bench for event_fifo_reader: a 1-cycle-latency FIFO model feeds the
// reader and a monitor logs every accepted beat for comparison.
module tb_event_fifo_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [17:0] fifo_q = '0;
    logic        fifo_re;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_start;
    logic        out_end;
    logic [15:0] event_count;
    logic        frame_error;
    logic        error_clear;
    logic        busy;

    always #5 clk = ~clk;

    event_fifo_reader #(
        .SKID_DEPTH (4),
        .DATA_WIDTH (16)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_enable      (enable),
        .i_fifo_empty  (fifo_empty),
        .i_fifo_q      (fifo_q),
        .o_fifo_re     (fifo_re),
        .o_out_data    (out_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_start   (out_start),
        .o_out_end     (out_end),
        .o_event_count (event_count),
        .o_frame_error (frame_error),
        .i_error_clear (error_clear),
        .o_busy        (busy)
    );

    // FIFO model: Q is valid exactly one cycle after a read enable.
    logic [17:0] fifo_mem [0:255];
    int unsigned fifo_wr   = 0;
    int unsigned fifo_rd   = 0;
    int unsigned re_pulses = 0;

    assign fifo_empty = (fifo_wr == fifo_rd);

    always @(posedge clk) begin
        if (fifo_re) begin
            fifo_q    <= fifo_mem[fifo_rd[7:0]];
            fifo_rd   <= fifo_rd + 1;
            re_pulses <= re_pulses + 1;
        end
    end

    // Beat monitor: {start, end, data} of every accepted word.
    logic [17:0] beat_mem [0:255];
    int unsigned beat_cnt = 0;

    always @(posedge clk) begin
        if (out_valid && out_ready && !rst) begin
            beat_mem[beat_cnt[7:0]] <= {out_start, out_end, out_data};
            beat_cnt <= beat_cnt + 1;
            $display("beat %0d data=%h start=%b end=%b", beat_cnt, out_data, out_start, out_end);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [17:0] w);
        fifo_mem[fifo_wr[7:0]] = w;
        fifo_wr = fifo_wr + 1;
    endtask

    function automatic logic [17:0] bt(input logic s, input logic e, input logic [15:0] d);
        return {s, e, d};
    endfunction

    task automatic wait_beats(input string tag, input int unsigned target);
        int unsigned n = 0;
        while (beat_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_beats"}, beat_cnt, target);
    endtask

    task automatic pulse_clear();
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
    endtask

    int unsigned base;
    int unsigned re0;
    logic        stable;

    initial begin
        rst = 1'b1; enable = 1'b0; out_ready = 1'b0; error_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_re", fifo_re, 1'b0);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_start_end", {out_start, out_end}, 2'b00);
        check_eq("rst_data", out_data, 16'h0000);
        check_eq("rst_count", event_count, 16'h0000);
        check_eq("rst_err_busy", {frame_error, busy}, 2'b00);
        rst = 1'b0;

        // Nominal event, ready held high
        out_ready = 1'b1;
        push_word(18'h10A5A); push_word(18'h00001); push_word(18'h00002); push_word(18'h2FFFF);
        base = beat_cnt;
        enable = 1'b1;
        #1 check_eq("t1_first_re", fifo_re, 1'b1);
        @(negedge clk); check_eq("t1_lat_n1_valid", out_valid, 1'b0);
        @(negedge clk); check_eq("t1_beat0", {out_valid, out_start, out_end, out_data}, {3'b110, 16'h0A5A});
        @(negedge clk); check_eq("t1_beat1", {out_valid, out_start, out_end, out_data}, {3'b100, 16'h0001});
        @(negedge clk); check_eq("t1_beat2", {out_valid, out_start, out_end, out_data}, {3'b100, 16'h0002});
        @(negedge clk); check_eq("t1_beat3", {out_valid, out_start, out_end, out_data}, {3'b101, 16'hFFFF});
        wait_beats("t1", base + 4);
        check_eq("t1_count", event_count, 16'd1);
        check_eq("t1_err", frame_error, 1'b0);
        check_eq("t1_busy", busy, 1'b0);

        // Backpressure: 8 words queued, ready low for 10 cycles
        out_ready = 1'b0;
        re0 = re_pulses; base = beat_cnt;
        push_word(18'h10100);
        for (int i = 1; i < 7; i++) push_word(18'h00100 + 18'(i));
        push_word(18'h20107);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 2 && !(out_valid && out_start && out_data == 16'h0100)) stable = 1'b0;
        end
        check_eq("bp_stable", stable, 1'b1);
        check_eq("bp_re_pulses", re_pulses - re0, 4);
        check_eq("bp_busy", busy, 1'b1);
        out_ready = 1'b1;
        wait_beats("bp", base + 8);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("bp_beat%0d", i), beat_mem[base + i], bt(i == 0, i == 7, 16'h0100 + 16'(i)));
        check_eq("bp_re_total", re_pulses - re0, 8);
        check_eq("bp_count", event_count, 16'd2);

        // Orphan data and reserved tag, then a good event
        base = beat_cnt;
        push_word(18'h01234); push_word(18'h35555);
        push_word(18'h10200); push_word(18'h00201); push_word(18'h20202);
        wait_beats("orph", base + 3);
        check_eq("orph_b0", beat_mem[base],     bt(1'b1, 1'b0, 16'h0200));
        check_eq("orph_b1", beat_mem[base + 1], bt(1'b0, 1'b0, 16'h0201));
        check_eq("orph_b2", beat_mem[base + 2], bt(1'b0, 1'b1, 16'h0202));
        check_eq("orph_err", frame_error, 1'b1);
        check_eq("orph_count", event_count, 16'd3);
        pulse_clear();
        check_eq("orph_err_cleared", frame_error, 1'b0);

        // Missing trailer: header, data, header, data, trailer
        base = beat_cnt;
        push_word(18'h10300); push_word(18'h00301); push_word(18'h10310);
        push_word(18'h00311); push_word(18'h20312);
        wait_beats("mt", base + 5);
        check_eq("mt_b0", beat_mem[base],     bt(1'b1, 1'b0, 16'h0300));
        check_eq("mt_b1", beat_mem[base + 1], bt(1'b0, 1'b0, 16'h0301));
        check_eq("mt_b2", beat_mem[base + 2], bt(1'b1, 1'b0, 16'h0310));
        check_eq("mt_b3", beat_mem[base + 3], bt(1'b0, 1'b0, 16'h0311));
        check_eq("mt_b4", beat_mem[base + 4], bt(1'b0, 1'b1, 16'h0312));
        check_eq("mt_err", frame_error, 1'b1);
        check_eq("mt_count", event_count, 16'd4);
        pulse_clear();

        // Enable drops one cycle after a read
        enable = 1'b0;
        base = beat_cnt; re0 = re_pulses;
        push_word(18'h10400); push_word(18'h00401); push_word(18'h00402); push_word(18'h20403);
        @(negedge clk); check_eq("en_low_re", fifo_re, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("en_re_pulses", re_pulses - re0, 1);
        check_eq("en_beats_held", beat_cnt, base + 1);
        check_eq("en_b0", beat_mem[base], bt(1'b1, 1'b0, 16'h0400));
        check_eq("en_busy_open", busy, 1'b1);
        enable = 1'b1;
        wait_beats("en_resume", base + 4);
        check_eq("en_b3", beat_mem[base + 3], bt(1'b0, 1'b1, 16'h0403));
        check_eq("en_count", event_count, 16'd5);
        check_eq("en_err", frame_error, 1'b0);

        // Reset in the middle of an event
        push_word(18'h10500); push_word(18'h00501); push_word(18'h00502); push_word(18'h20503);
        @(negedge clk); @(negedge clk);
        check_eq("mrst_pre_valid", {out_valid, busy}, 2'b11);
        rst = 1'b1;
        #1;
        check_eq("mrst_valid", out_valid, 1'b0);
        check_eq("mrst_re", fifo_re, 1'b0);
        check_eq("mrst_start_end", {out_start, out_end}, 2'b00);
        check_eq("mrst_data", out_data, 16'h0000);
        check_eq("mrst_count", event_count, 16'h0000);
        check_eq("mrst_err_busy", {frame_error, busy}, 2'b00);
        fifo_wr = fifo_rd;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        base = beat_cnt;
        push_word(18'h10600); push_word(18'h00601); push_word(18'h20602);
        wait_beats("post_rst", base + 3);
        check_eq("post_rst_b0", beat_mem[base],     bt(1'b1, 1'b0, 16'h0600));
        check_eq("post_rst_b2", beat_mem[base + 2], bt(1'b0, 1'b1, 16'h0602));
        check_eq("post_rst_count", event_count, 16'd1);
        check_eq("post_rst_err", frame_error, 1'b0);

        // Event counter wrap
        force dut.r_event_count = 16'hFFFF;
        #1 release dut.r_event_count;
        check_eq("wrap_preload", event_count, 16'hFFFF);
        base = beat_cnt;
        push_word(18'h10700); push_word(18'h20701);
        wait_beats("wrap", base + 2);
        check_eq("wrap_count", event_count, 16'h0000);
        check_eq("wrap_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
